// File: rtl/stack_pointer_unit.sv
// -----------------------------------------------------------------------------
// stack_pointer_unit
//
// Owns the stack pointer (SP) of a downward-growing stack. It sequences
// single-word push/pop accesses to data memory and mirrors every SP update
// into register 0 of the register file. Overflow and underflow are caught
// before any memory access is started. They park the unit in a fault state
// until software clears it.
//
// Ports
//   clk                        system clock, all state on the rising edge
//   reset_n                    asynchronous active-low reset
//   push_request               push one word (held until accepted)
//   pop_request                pop one word (held until accepted)
//   sp_load_enable             load SP directly from sp_load_value
//   sp_load_value              new SP value for a load
//   memory_ready               data memory completes the current access
//   fault_clear                leave the fault state and clear both flags
//   request_accept             push/pop taken this cycle
//   stack_memory_address       word address of the current stack access
//   stack_memory_write_enable  push access active
//   stack_memory_read_enable   pop access active
//   stack_write_enable         register-0 write strobe
//   stack_register_write_data  updated SP value for register 0
//   busy                       memory access in progress
//   overflow / underflow       sticky fault flags
//   stack_depth                STACK_BASE - SP
// -----------------------------------------------------------------------------
module stack_pointer_unit #(
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] STACK_BASE  = 16'hFFFF,
  parameter logic [DATA_WIDTH-1:0] STACK_LIMIT = 16'hFF00
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_request,
  input  logic                  pop_request,
  input  logic                  sp_load_enable,
  input  logic [DATA_WIDTH-1:0] sp_load_value,
  input  logic                  memory_ready,
  input  logic                  fault_clear,
  output logic                  request_accept,
  output logic [DATA_WIDTH-1:0] stack_memory_address,
  output logic                  stack_memory_write_enable,
  output logic                  stack_memory_read_enable,
  output logic                  stack_write_enable,
  output logic [DATA_WIDTH-1:0] stack_register_write_data,
  output logic                  busy,
  output logic                  overflow,
  output logic                  underflow,
  output logic [DATA_WIDTH-1:0] stack_depth
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PUSH_ACCESS = 2'd1,
    POP_ACCESS  = 2'd2,
    FAULT       = 2'd3
  } state_t;

  state_t                state_r;
  logic [DATA_WIDTH-1:0] sp_r;
  logic                  overflow_r;
  logic                  underflow_r;

  // Wrap-around neighbours of SP. A push writes below SP and a pop reads at SP.
  logic [DATA_WIDTH-1:0] sp_dec_s;
  logic [DATA_WIDTH-1:0] sp_inc_s;
  assign sp_dec_s = sp_r - DATA_WIDTH'(1);
  assign sp_inc_s = sp_r + DATA_WIDTH'(1);

  // Control FSM: state, stack pointer and sticky fault flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      sp_r        <= STACK_BASE;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // A load wins over push, and push wins over pop. Losers are simply not accepted.
          if (sp_load_enable) begin
            sp_r <= sp_load_value;
          end else if (push_request) begin
            if (sp_r == STACK_LIMIT) begin
              overflow_r <= 1'b1;
              state_r    <= FAULT;
            end else begin
              state_r <= PUSH_ACCESS;
            end
          end else if (pop_request) begin
            if (sp_r == STACK_BASE) begin
              underflow_r <= 1'b1;
              state_r     <= FAULT;
            end else begin
              state_r <= POP_ACCESS;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        PUSH_ACCESS: begin
          if (memory_ready) begin
            sp_r    <= sp_dec_s;
            state_r <= IDLE;
          end else begin
            state_r <= PUSH_ACCESS;
          end
        end
        POP_ACCESS: begin
          if (memory_ready) begin
            sp_r    <= sp_inc_s;
            state_r <= IDLE;
          end else begin
            state_r <= POP_ACCESS;
          end
        end
        FAULT: begin
          if (fault_clear) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= FAULT;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Output decode. Accept and writeback must respond in the same cycle as the
  // request or memory_ready, so they are decoded from the registered state and
  // the live inputs. Gating with reset_n keeps every strobe low while reset is held.
  always_comb begin
    request_accept            = 1'b0;
    stack_memory_address      = sp_r;
    stack_memory_write_enable = 1'b0;
    stack_memory_read_enable  = 1'b0;
    stack_write_enable        = 1'b0;
    stack_register_write_data = sp_r;
    busy                      = 1'b0;
    if (reset_n) begin
      case (state_r)
        IDLE: begin
          if (sp_load_enable) begin
            stack_write_enable        = 1'b1;
            stack_register_write_data = sp_load_value;
          end else if (push_request) begin
            request_accept = (sp_r != STACK_LIMIT);
          end else if (pop_request) begin
            request_accept = (sp_r != STACK_BASE);
          end else begin
            request_accept = 1'b0;
          end
        end
        PUSH_ACCESS: begin
          stack_memory_address      = sp_dec_s;
          stack_memory_write_enable = 1'b1;
          busy                      = 1'b1;
          if (memory_ready) begin
            stack_write_enable        = 1'b1;
            stack_register_write_data = sp_dec_s;
          end else begin
            stack_write_enable = 1'b0;
          end
        end
        POP_ACCESS: begin
          stack_memory_read_enable = 1'b1;
          busy                     = 1'b1;
          if (memory_ready) begin
            stack_write_enable        = 1'b1;
            stack_register_write_data = sp_inc_s;
          end else begin
            stack_write_enable = 1'b0;
          end
        end
        FAULT: begin
          busy = 1'b0;
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end else begin
      request_accept     = 1'b0;
      stack_write_enable = 1'b0;
    end
  end

  assign overflow    = overflow_r;
  assign underflow   = underflow_r;
  assign stack_depth = STACK_BASE - sp_r;

endmodule
